// File: rtl/truth_table_reader_pkg.sv
// Shared state encoding and sizing helpers for truth_table_reader.
// Pure declarations, so there is no latency or backpressure to describe.
package truth_table_reader_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRIVE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = IDLE,
        ST_DRIVE = DRIVE,
        ST_WAIT  = WAIT,
        ST_DONE  = DONE
    } state_t;

    localparam int N_MAX = 4;

    function automatic int MASK_W(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/truth_table_reader_if.sv
// Controller/function-block bundle for truth_table_reader; count exists only with MINTERM_COUNT_EN.
// No storage or flow control: start is a level sampled by the reader, done is a one-cycle pulse.
interface truth_table_reader_if
    import truth_table_reader_pkg::*;
#(
    parameter int N = 3
) ();
    localparam int MW = MASK_W(N);

    logic          start;
    logic          f_in;
    logic [N-1:0]  vec;
    logic [MW-1:0] mask;
    logic          busy;
    logic          done;
`ifdef MINTERM_COUNT_EN
    logic [N:0]    count;

    modport master (output start, output f_in, input vec, input mask, input busy, input done, input count);
    modport slave  (input start, input f_in, output vec, output mask, output busy, output done, output count);
`else
    modport master (output start, output f_in, input vec, input mask, input busy, input done);
    modport slave  (input start, input f_in, output vec, output mask, output busy, output done);
`endif
endinterface

// File: rtl/truth_table_reader_popcount_mask.sv
// Combinational ones counter over the captured minterm mask.
// Zero latency; no handshake, the result follows din within the same cycle.
module popcount_mask #(
    parameter int W  = 8,
    parameter int CW = $clog2(W) + 1
) (
    input  logic [W-1:0]  din,
    output logic [CW-1:0] ones
);

    always_comb begin
        ones = '0;
        for (int i = 0; i < W; i++) begin
            ones = ones + CW'(din[i]);
        end
    end

endmodule

// File: rtl/truth_table_reader.sv
// Sweeps all 2^N vectors onto a combinational function and captures its minterm mask (+count with MINTERM_COUNT_EN).
// done arrives 2^N*(1+SETTLE)+1 cycles after start; start while busy is dropped, never queued.
module truth_table_reader
    import truth_table_reader_pkg::*;
#(
    parameter int N      = 3,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    truth_table_reader_if.slave bus
);

    localparam int            MW        = MASK_W(N);
    localparam logic [N-1:0]  VEC_LAST  = {N{1'b1}};
    localparam logic [2:0]    WAIT_LAST = (SETTLE > 0) ? 3'(SETTLE - 1) : 3'd0;

    state_t        state_q, state_d;
    logic [N-1:0]  vec_q, vec_d;
    logic [MW-1:0] mask_q, mask_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [2:0]    wcnt_q, wcnt_d;
    logic          sample;

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        mask_d  = mask_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        wcnt_d  = wcnt_q;
        sample  = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_d = ST_DRIVE;
                    vec_d   = '0;
                    mask_d  = '0;
                    busy_d  = 1'b1;
                    wcnt_d  = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                if (SETTLE == 0) begin
                    sample = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wcnt_q == WAIT_LAST) begin
                    sample = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + 3'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Each sample either advances the vector or closes the sweep; vec never wraps here.
        if (sample) begin
            mask_d[vec_q] = bus.f_in;
            wcnt_d        = '0;
            if (vec_q == VEC_LAST) begin
                state_d = ST_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end else begin
                vec_d   = vec_q + 1'b1;
                state_d = ST_DRIVE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            mask_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            mask_q  <= mask_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            wcnt_q  <= wcnt_d;
        end
    end

    assign bus.vec  = vec_q;
    assign bus.mask = mask_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

`ifdef MINTERM_COUNT_EN
    // Counting mask_d keeps count aligned with mask, including the clear on start.
    logic [N:0] ones;
    logic [N:0] count_q;

    popcount_mask #(.W(MW), .CW(N + 1)) u_popcount (
        .din  (mask_d),
        .ones (ones)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= ones;
    end

    assign bus.count = count_q;
`endif

endmodule

// File: tb/tb_truth_table_reader.sv
// Scoreboarded bench for truth_table_reader: N=3/SETTLE=1 and N=2/SETTLE=0 instances.
module tb_truth_table_reader;
    import truth_table_reader_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    truth_table_reader_if #(.N(3)) bus_a ();
    truth_table_reader_if #(.N(2)) bus_b ();

    int fsel = 0;
    always_comb begin
        case (fsel)
            0:       bus_a.f_in = bus_a.vec[1] ^ bus_a.vec[0];
            1:       bus_a.f_in = bus_a.vec[2] & bus_a.vec[1];
            2:       bus_a.f_in = 1'b0;
            default: bus_a.f_in = 1'b1;
        endcase
    end
    assign bus_b.f_in = bus_b.vec[0];

    truth_table_reader #(.N(3), .SETTLE(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    truth_table_reader #(.N(2), .SETTLE(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_mask_q[$];
    int         exp_cnt_q[$];
    int         exp_lat_q[$];

    // Drives one sweep on dut_a and returns what was seen at done; poke re-pulses start mid-sweep.
    task automatic sweep_a(input int sel, input int poke, output int dcyc, output logic [7:0] m,
                           output int c, output logic busy1);
        fsel = sel;
        dcyc = -1; m = 'x; c = -1; busy1 = 1'bx;
        @(negedge clk) bus_a.start = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            bus_a.start = (k == poke);
            if (k == 1) busy1 = bus_a.busy;
            if (bus_a.done === 1'b1) begin
                dcyc = k;
                m    = bus_a.mask;
`ifdef MINTERM_COUNT_EN
                c    = int'(bus_a.count);
`endif
                break;
            end
        end
        bus_a.start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus_a.vec !== 3'd0)  begin errors++; $display("FAIL reset_vec got %h expected 0", bus_a.vec); end
        checks++; if (bus_a.mask !== 8'h0) begin errors++; $display("FAIL reset_mask got %h expected 00", bus_a.mask); end
        checks++; if (bus_a.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", bus_a.busy); end
        checks++; if (bus_a.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", bus_a.done); end
`ifdef MINTERM_COUNT_EN
        checks++; if (bus_a.count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d expected 0", bus_a.count); end
`endif
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_sweep(input string name, input int dcyc, input logic [7:0] m, input int c);
        int         lat;
        logic [7:0] em;
        int         ec;
        lat = exp_lat_q.pop_front();
        em  = exp_mask_q.pop_front();
        ec  = exp_cnt_q.pop_front();
        checks++; if (dcyc != lat) begin errors++; $display("FAIL %s_latency got %0d expected %0d", name, dcyc, lat); end
        checks++; if (m !== em)    begin errors++; $display("FAIL %s_mask got %h expected %h", name, m, em); end
`ifdef MINTERM_COUNT_EN
        checks++; if (c != ec)     begin errors++; $display("FAIL %s_count got %0d expected %0d", name, c, ec); end
`else
        if (c != -1 && ec < 0) $display("note: count unexpected");
`endif
    endtask

    task automatic test_xor();
        int dcyc, c; logic [7:0] m; logic b1;
        exp_mask_q.push_back(8'h66); exp_cnt_q.push_back(4); exp_lat_q.push_back(17);
        sweep_a(0, 0, dcyc, m, c, b1);
        check_sweep("xor", dcyc, m, c);
        checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL xor_busy_rise got %b expected 1", b1); end
        checks++; if (bus_a.vec !== 3'd7) begin errors++; $display("FAIL xor_vec_hold got %0d expected 7", bus_a.vec); end
        @(negedge clk);
        checks++; if (bus_a.done !== 1'b0) begin errors++; $display("FAIL xor_done_pulse got %b expected 0", bus_a.done); end
        checks++; if (bus_a.mask !== 8'h66) begin errors++; $display("FAIL xor_mask_hold got %h expected 66", bus_a.mask); end
    endtask

    task automatic test_const();
        int dcyc, c; logic [7:0] m; logic b1;
        exp_mask_q.push_back(8'h00); exp_cnt_q.push_back(0); exp_lat_q.push_back(17);
        sweep_a(2, 0, dcyc, m, c, b1);
        check_sweep("const0", dcyc, m, c);
        @(negedge clk);
        checks++; if (bus_a.done !== 1'b0) begin errors++; $display("FAIL const0_done_pulse got %b expected 0", bus_a.done); end
        exp_mask_q.push_back(8'hFF); exp_cnt_q.push_back(8); exp_lat_q.push_back(17);
        sweep_a(3, 0, dcyc, m, c, b1);
        check_sweep("const1", dcyc, m, c);
        @(negedge clk);
        checks++; if (bus_a.done !== 1'b0) begin errors++; $display("FAIL const1_done_pulse got %b expected 0", bus_a.done); end
    endtask

    task automatic test_start_busy();
        int dcyc, c; logic [7:0] m; logic b1;
        exp_mask_q.push_back(8'h66); exp_cnt_q.push_back(4); exp_lat_q.push_back(17);
        sweep_a(0, 5, dcyc, m, c, b1);
        check_sweep("start_busy", dcyc, m, c);
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int dcyc, c; logic [7:0] m;
        exp_mask_q.push_back(8'hC0); exp_cnt_q.push_back(2); exp_lat_q.push_back(17);
        exp_mask_q.push_back(8'h66); exp_cnt_q.push_back(4); exp_lat_q.push_back(17);
        fsel = 1;
        @(negedge clk) bus_a.start = 1'b1;
        dcyc = -1; m = 'x; c = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            bus_a.start = 1'b0;
            if (bus_a.done === 1'b1) begin
                dcyc = k; m = bus_a.mask;
`ifdef MINTERM_COUNT_EN
                c = int'(bus_a.count);
`endif
                break;
            end
        end
        check_sweep("b2b_first", dcyc, m, c);
        // Hold start through the DONE cycle to chain the second sweep.
        bus_a.start = 1'b1;
        fsel = 0;
        @(negedge clk);
        bus_a.start = 1'b0;
        checks++; if (bus_a.busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_reassert got %b expected 1", bus_a.busy); end
        dcyc = -1; m = 'x; c = -1;
        for (int k = 2; k <= 40; k++) begin
            @(negedge clk);
            if (bus_a.done === 1'b1) begin
                dcyc = k; m = bus_a.mask;
`ifdef MINTERM_COUNT_EN
                c = int'(bus_a.count);
`endif
                break;
            end
        end
        check_sweep("b2b_second", dcyc, m, c);
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int dcyc, c, dones; logic [7:0] m; logic b1;
        fsel = 0;
        @(negedge clk) bus_a.start = 1'b1;
        @(negedge clk) bus_a.start = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (bus_a.vec !== 3'd0)  begin errors++; $display("FAIL mid_reset_vec got %h expected 0", bus_a.vec); end
        checks++; if (bus_a.mask !== 8'h0) begin errors++; $display("FAIL mid_reset_mask got %h expected 00", bus_a.mask); end
        checks++; if (bus_a.busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy got %b expected 0", bus_a.busy); end
        checks++; if (dut_a.state_q !== ST_IDLE) begin errors++; $display("FAIL mid_reset_state got %0d expected 0", dut_a.state_q); end
`ifdef MINTERM_COUNT_EN
        checks++; if (bus_a.count !== 4'd0) begin errors++; $display("FAIL mid_reset_count got %0d expected 0", bus_a.count); end
`endif
        rst_n = 1'b1;
        dones = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus_a.done !== 1'b0) dones++;
        end
        checks++; if (dones != 0) begin errors++; $display("FAIL mid_reset_no_done got %0d expected 0", dones); end
        exp_mask_q.push_back(8'h66); exp_cnt_q.push_back(4); exp_lat_q.push_back(17);
        sweep_a(0, 0, dcyc, m, c, b1);
        check_sweep("after_reset", dcyc, m, c);
        @(negedge clk);
    endtask

    task automatic test_settle0();
        int dcyc; logic [3:0] m; int c;
        dcyc = -1; m = 'x; c = -1;
        @(negedge clk) bus_b.start = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            bus_b.start = 1'b0;
            if (bus_b.done === 1'b1) begin
                dcyc = k; m = bus_b.mask;
`ifdef MINTERM_COUNT_EN
                c = int'(bus_b.count);
`endif
                break;
            end
        end
        exp_mask_q.push_back(8'h0A); exp_cnt_q.push_back(2); exp_lat_q.push_back(5);
        check_sweep("settle0", dcyc, {4'h0, m}, c);
        @(negedge clk);
        checks++; if (bus_b.done !== 1'b0) begin errors++; $display("FAIL settle0_done_pulse got %b expected 0", bus_b.done); end
    endtask

    initial begin
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        test_reset();
        test_xor();
        test_const();
        test_start_busy();
        test_back_to_back();
        test_reset_mid();
        test_settle0();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/truth_table_reader.md
# truth_table_reader

Sequential companion to the team's combinational sum-of-products function blocks. The function block maps an input vector to a single output; this block reads its truth table back. On a start pulse it sweeps every input combination onto the function's inputs, samples the function output after a fixed settle time, and returns the resulting minterm mask, with a `done` handshake. It sits between a test controller and any N-input single-output combinational function block.

## Interface
Parameters:
- `N`, 3: number of function inputs. Legal range is 1..4.
- `SETTLE`, 1: wait cycles between driving a vector and sampling `f_in`. Legal range is 0..7.

Ports:
- `clk`, input, 1: the single clock. All state changes on its rising edge.
- `rst_n`, input, 1: reset. It is synchronous and active-low.
- `start`, input, 1: sweep request. Sampled only in IDLE or DONE.
- `f_in`, input, 1: output of the function under read.
- `vec`, output, N: input vector driven to the function. `vec[N-1]` is the most significant input (x for N=3).
- `mask`, output, 2^N: captured minterms. `mask[i]` is the `f_in` value sampled while `vec == i`.
- `busy`, output, 1: high while a sweep is in progress.
- `done`, output, 1: one-cycle pulse when `mask` becomes valid.
- `count`, output, N+1: number of ones in `mask`. Present only with `MINTERM_COUNT_EN` defined.

## Operation
- States are IDLE, DRIVE, WAIT, DONE.
- IDLE:
  - `start` = 1 goes to DRIVE.
  - On the same edge: `vec` <- 0, `mask` <- 0, `busy` <- 1, wait counter <- 0.
- DRIVE:
  - With SETTLE = 0: sample `f_in` into `mask[vec]` on this edge.
  - With SETTLE > 0: go to WAIT.
- WAIT:
  - Increment the wait counter each cycle.
  - When the counter reaches SETTLE-1: sample `f_in` into `mask[vec]` and leave WAIT.
- After each sample:
  - If `vec` is not 2^N-1: `vec` <- `vec`+1, return to DRIVE, clear the wait counter.
  - If `vec` is 2^N-1: go to DONE, `busy` <- 0, `done` <- 1. `vec` holds at 2^N-1.
- DONE lasts exactly one cycle, during which `done` = 1.
  - `start` = 1 in DONE begins a new sweep immediately, exactly as from IDLE.
  - Otherwise return to IDLE.
- `mask` is never partially overwritten outside a sweep. It holds its value until the next accepted `start`.
- `start` while `busy` is ignored: no restart and no queuing.
- `vec` wraps only by restart and never increments past 2^N-1.
- `f_in` is sampled as given. An X on `f_in` propagates into `mask`, and the bench flags it.

## Timing
- Reset value of every output is 0: `vec`, `mask`, `busy`, `done` and `count`. Reset returns to IDLE.
- Reset asserted mid-sweep aborts the sweep on that edge. All outputs are 0 on the next cycle, and no `done` is issued.
- Each vector is held for 1+SETTLE cycles.
- Latency:
  - `busy` rises 1 cycle after `start`.
  - `done` rises 2^N·(1+SETTLE)+1 cycles after the `start` edge. With N=3 and SETTLE=1 this is 17.
- `mask` is stable and valid in the same cycle that `done` = 1.
- `f_in` must be a combinational function of `vec` that settles within SETTLE+1 cycles.

## Configuration
- `MINTERM_COUNT_EN`:
  - Defined: `count` port exists. It is registered and updates in the same edge as `mask`, so it is valid together with `done`. It resets to 0 and clears on `start`.
  - Not defined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package contents:
  - State encoding localparams: IDLE=2'd0, DRIVE=2'd1, WAIT=2'd2, DONE=2'd3.
  - `N_MAX` = 4.
  - Width helper `MASK_W(n)` = 1<<n.
- Sub-module: one, `popcount_mask`. It is a combinational ones counter over 2^N bits and is instantiated only under `MINTERM_COUNT_EN`.
- The FSM, vector counter and wait counter stay in the top module.

## Test plan
- **y XOR z, N=3, SETTLE=1:** connect `f_in` = `vec[1]^vec[0]` and pulse `start` -> `done` 17 cycles later and `mask` = 8'h66. With the macro, `count` = 4.
- **Constant function:** `f_in` tied 0, then repeat with `f_in` tied 1 -> `mask` = 8'h00 and then 8'hFF, each with exactly one `done` pulse. `count` = 0 and then 8.
- **Start while busy:** pulse `start` again at cycle 5 of the sweep -> `done` timing unchanged, `mask` = 8'h66.
- **Back-to-back sweeps:**
  - Stimulus: `f_in` is x AND y for sweep 1 and XOR for sweep 2. `start` is held high in the DONE cycle of sweep 1.
  - Response: `mask` = 8'hC0 when sweep 1 is done. `busy` re-asserts on the next cycle. `mask` = 8'h66 when sweep 2 is done.
- **Reset mid-sweep:** pull `rst_n` low at cycle 9 -> next cycle all outputs 0, no `done`, state IDLE. A new `start` yields 8'h66.
- **SETTLE=0, N=2:** `f_in` = `vec[0]` -> `done` 5 cycles after `start` and `mask` = 4'hA.
